// File: rtl/apb_pkg.sv
// APB requester shared types: FSM state, response code and command payload.
// Default widths match the requester's default DATA_WIDTH/ADDR_WIDTH.
package apb_pkg;

  localparam int unsigned APB_DATA_W = 16;
  localparam int unsigned APB_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic {
    APB_OK      = 1'b0,
    APB_TIMEOUT = 1'b1
  } apb_resp_e;

  typedef struct packed {
    logic                  wr;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_req_watchdog.sv
// ACCESS-phase timeout counter for apb_requester (built only with APB_REQ_TIMEOUT_EN).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   clear      - hold the count at zero (any cycle outside ACCESS)
//   enable     - count one waited ACCESS cycle
//   expired_c  - combinational: count has reached TIMEOUT_CYCLES-1
module apb_req_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturate at LAST so the count never wraps while the FSM aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB requester: converts a valid/ready command stream into APB transfers and
// returns completion on a one-cycle response strobe.
// Optional ACCESS timeout enabled by defining APB_REQ_TIMEOUT_EN.
// Ports:
//   clk, rst                              - PCLK, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_wr/addr/wdata - command stream (cmd_ready is combinational)
//   rsp_valid, rsp_rdata, rsp_err         - registered response, rsp_valid is one pulse
//   psel, penable, pwrite, paddr, pwdata  - registered APB request
//   pready, prdata                        - APB completer response
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  apb_state_e            state_q, state_d;
  apb_resp_e             resp_q, resp_d;
  logic                  psel_d, penable_d, pwrite_d, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;
  logic                  timeout_c;

  // A new command can be taken in IDLE or on the completing ACCESS cycle.
  assign cmd_ready = !rst && ((state_q == IDLE) || ((state_q == ACCESS) && pready));

`ifdef APB_REQ_TIMEOUT_EN
  apb_req_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q != ACCESS),
    .enable   ((state_q == ACCESS) && !pready),
    .expired_c(timeout_c)
  );
`else
  logic unused_timeout;
  assign timeout_c      = 1'b0;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_wr;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a coincident timeout expiry.
        if (pready) begin
          rsp_valid_d = 1'b1;
          resp_d      = APB_OK;
          rsp_rdata_d = pwrite ? '0 : prdata;
          if (cmd_valid) begin
            pwrite_d  = cmd_wr;
            paddr_d   = cmd_addr;
            pwdata_d  = cmd_wdata;
            penable_d = 1'b0;
            state_d   = SETUP;
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (timeout_c) begin
          rsp_valid_d = 1'b1;
          resp_d      = APB_TIMEOUT;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      resp_q    <= APB_OK;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

  assign rsp_err = (resp_q == APB_TIMEOUT);

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a small memory-backed APB completer.
module tb_apb_requester;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  int total = 0;
  int bad   = 0;
  logic [63:0] got, want;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  apb_requester #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer: reads are combinational from memory, writes land on the completing edge.
  assign prdata = mem[paddr];
  always @(posedge clk) begin
    if (!rst && psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Zero-wait transfer from IDLE; returns in the response cycle.
  task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive_cmd(wr, a, d);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #3;
    got  = 64'({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata, cmd_ready});
    want = 64'(0);
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_vals got=%h want=%h", got, want); end
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_idle_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_single_write();
    drive_cmd(1'b1, 10'h005, 16'hBEEF);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    got  = 64'({psel, penable, pwrite, paddr, pwdata, cmd_ready});
    want = 64'({1'b1, 1'b0, 1'b1, 10'h005, 16'hBEEF, 1'b0});
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_setup got=%h want=%h", got, want); end
    tick();
    got  = 64'({psel, penable, rsp_valid});
    want = 64'({1'b1, 1'b1, 1'b0});
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_access got=%h want=%h", got, want); end
    tick();
    got  = 64'({rsp_valid, rsp_err, rsp_rdata, psel, penable});
    want = 64'({1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
    total++;
    if (got !== want) begin bad++; $display("FAIL wr_rsp got=%h want=%h", got, want); end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_pulse got=%b want=0", rsp_valid); end
  endtask

  task automatic test_wait_read();
    drive_cmd(1'b0, 10'h005, 16'h0000);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 5) begin pready = 1'b1; #1; end
      got  = 64'({psel, penable, pwrite, paddr, rsp_valid, cmd_ready});
      want = 64'({1'b1, 1'b1, 1'b0, 10'h005, 1'b0, (k == 5)});
      total++;
      if (got !== want) begin bad++; $display("FAIL rd_wait_c%0d got=%h want=%h", k, got, want); end
    end
    tick();
    got  = 64'({rsp_valid, rsp_err, rsp_rdata});
    want = 64'({1'b1, 1'b0, 16'hBEEF});
    total++;
    if (got !== want) begin bad++; $display("FAIL rd_wait_rsp got=%h want=%h", got, want); end
    tick();
  endtask

  task automatic test_back_to_back();
    int rsp_cnt = 0;
    int ei;
    drive_cmd(1'b1, 10'h000, 16'h1111);
    pready = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      ei   = (k - 1) / 2;
      got  = 64'({psel, penable, paddr, pwdata, rsp_valid});
      want = 64'({1'b1, (k % 2 == 0), AW'(ei), DW'(16'h1111 * (ei + 1)), (k % 2 == 1) && (k >= 3)});
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_c%0d got=%h want=%h", k, got, want); end
      if (k % 2 == 1) begin
        if ((k + 1) / 2 < 4) drive_cmd(1'b1, AW'((k + 1) / 2), DW'(16'h1111 * ((k + 1) / 2 + 1)));
        else cmd_valid = 1'b0;
      end
      if (rsp_valid === 1'b1) rsp_cnt++;
      tick();
    end
    if (rsp_valid === 1'b1) rsp_cnt++;
    got  = 64'({psel, penable, paddr, rsp_valid});
    want = 64'({1'b0, 1'b0, 10'h003, 1'b1});
    total++;
    if (got !== want) begin bad++; $display("FAIL b2b_end got=%h want=%h", got, want); end
    total++;
    if (rsp_cnt != 4) begin bad++; $display("FAIL b2b_rsp_count got=%0d want=4", rsp_cnt); end
    tick();
    do_xfer(1'b0, 10'h000, 16'h0000);
    total++;
    if (rsp_rdata !== 16'h1111) begin bad++; $display("FAIL b2b_rd0 got=%h want=1111", rsp_rdata); end
    do_xfer(1'b0, 10'h003, 16'h0000);
    total++;
    if (rsp_rdata !== 16'h4444) begin bad++; $display("FAIL b2b_rd3 got=%h want=4444", rsp_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    drive_cmd(1'b0, 10'h007, 16'h0000);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    got  = 64'({psel, penable, paddr});
    want = 64'({1'b1, 1'b1, 10'h007});
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_mid_access got=%h want=%h", got, want); end
    #2 rst = 1'b1;
    #1;
    got  = 64'({psel, penable, cmd_ready, rsp_valid});
    want = 64'(0);
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_mid_async got=%h want=%h", got, want); end
    tick();
    rst    = 1'b0;
    pready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid !== 1'b0 || psel !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rst_mid_quiet got=%0d want=0", stray); end
    do_xfer(1'b0, 10'h005, 16'h0000);
    got  = 64'({rsp_valid, rsp_err, rsp_rdata});
    want = 64'({1'b1, 1'b0, 16'hBEEF});
    total++;
    if (got !== want) begin bad++; $display("FAIL rst_mid_after got=%h want=%h", got, want); end
    tick();
  endtask

  task automatic test_setup_cmd();
    drive_cmd(1'b1, 10'h010, 16'hAAAA);
    pready = 1'b1;
    tick();
    drive_cmd(1'b0, 10'h005, 16'h0000);
    #1;
    got  = 64'({cmd_ready, paddr});
    want = 64'({1'b0, 10'h010});
    total++;
    if (got !== want) begin bad++; $display("FAIL setup_hold got=%h want=%h", got, want); end
    tick();
    got  = 64'({paddr, pwrite, penable, cmd_ready});
    want = 64'({10'h010, 1'b1, 1'b1, 1'b1});
    total++;
    if (got !== want) begin bad++; $display("FAIL setup_access got=%h want=%h", got, want); end
    tick();
    cmd_valid = 1'b0;
    got  = 64'({psel, penable, paddr, pwrite, rsp_valid});
    want = 64'({1'b1, 1'b0, 10'h005, 1'b0, 1'b1});
    total++;
    if (got !== want) begin bad++; $display("FAIL setup_next got=%h want=%h", got, want); end
    tick();
    tick();
    got  = 64'({rsp_valid, rsp_rdata});
    want = 64'({1'b1, 16'hBEEF});
    total++;
    if (got !== want) begin bad++; $display("FAIL setup_rsp got=%h want=%h", got, want); end
    tick();
  endtask

`ifdef APB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    for (int rep = 0; rep < 2; rep++) begin
      drive_cmd(1'b0, 10'h005, 16'h0000);
      pready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      for (int k = 2; k <= 9; k++) begin
        tick();
        if (k == 9 && rep == 1) pready = 1'b1;
        got  = 64'({psel, penable, rsp_valid});
        want = 64'({1'b1, 1'b1, 1'b0});
        total++;
        if (got !== want) begin bad++; $display("FAIL tmo%0d_c%0d got=%h want=%h", rep, k, got, want); end
      end
      tick();
      got  = 64'({rsp_valid, rsp_err, rsp_rdata, psel, penable});
      want = (rep == 0) ? 64'({1'b1, 1'b1, 16'h0000, 1'b0, 1'b0})
                        : 64'({1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0});
      total++;
      if (got !== want) begin bad++; $display("FAIL tmo%0d_rsp got=%h want=%h", rep, got, want); end
      pready = 1'b1;
      tick();
    end
  endtask
`else
  task automatic test_long_wait();
    int broken = 0;
    drive_cmd(1'b0, 10'h005, 16'h0000);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0) broken++;
    end
    total++;
    if (broken != 0) begin bad++; $display("FAIL long_wait_hold got=%0d want=0", broken); end
    pready = 1'b1;
    tick();
    got  = 64'({rsp_valid, rsp_err, rsp_rdata});
    want = 64'({1'b1, 1'b0, 16'hBEEF});
    total++;
    if (got !== want) begin bad++; $display("FAIL long_wait_rsp got=%h want=%h", got, want); end
    tick();
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_reset_mid();
    test_setup_cmd();
`ifdef APB_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
